// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM states, parity encodings and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PAR_NONE  = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_ODD   = 2;
  localparam int DATA_BITS = 8;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: down-counter reloaded on restart or expiry, one-cycle bit_tick at zero.
module baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'd0;
    end else if (restart || count == 16'd0) begin
      count <= RELOAD;
    end else begin
      count <= count - 16'd1;
    end
  end

  // While held in restart the timer is not running, so no tick is reported.
  assign bit_tick = !restart && (count == 16'd0);

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes straight from a FIFO and serialises start/data/parity/stop.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output state_t     state
);

  state_t         state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     idx_q, idx_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           rd_en_q, rd_en_d;
  logic           done_q, done_d;
  logic           bit_tick;

  // The timer is held in restart while idle so the start edge begins a full bit period.
  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (sys_clk),
    .rst     (rst),
    .restart (state_q == ST_IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= 8'h00;
      idx_q   <= 3'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_enable && !fifo_empty) begin
          shreg_d = fifo_data;
          par_d   = parity_bit(fifo_data, PARITY);
          rd_en_d = 1'b1;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The line already carries shreg_q[0]; shifting exposes the next bit at [1].
        if (bit_tick) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign state      = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader with a behavioural FIFO and per-cycle line checks.
module tb_uart_tx_fifo_reader;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       sys_clk    = 1'b0;
  logic       rst        = 1'b1;
  logic       tx_enable  = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = 8'h00;
  logic       fifo_rd_en, tx, busy, frame_done;
  state_t     state;

  logic       p_enable = 1'b0;
  logic       p_empty  = 1'b1;
  logic [7:0] p_data   = 8'h07;
  logic       p1_rd_en, p1_tx, p1_busy, p1_done;
  logic       p2_rd_en, p2_tx, p2_busy, p2_done;
  state_t     p1_state, p2_state;

  int         vectors    = 0;
  int         miscompares = 0;
  logic [7:0] fifo_q[$];
  int         pop_wait   = 0;
  int         rd_pulses  = 0;
  int         base;

  always #5 sys_clk = ~sys_clk;

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .PARITY(PAR_NONE)) dut (
    .sys_clk(sys_clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .frame_done(frame_done), .state(state)
  );

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN)) dut_p1 (
    .sys_clk(sys_clk), .rst(rst), .tx_enable(p_enable), .fifo_empty(p_empty),
    .fifo_data(p_data), .fifo_rd_en(p1_rd_en), .tx(p1_tx), .busy(p1_busy),
    .frame_done(p1_done), .state(p1_state)
  );

  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .PARITY(PAR_ODD)) dut_p2 (
    .sys_clk(sys_clk), .rst(rst), .tx_enable(p_enable), .fifo_empty(p_empty),
    .fifo_data(p_data), .fifo_rd_en(p2_rd_en), .tx(p2_tx), .busy(p2_busy),
    .frame_done(p2_done), .state(p2_state)
  );

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // FIFO model: sees rd_en on a rising edge, commits the pop two edges later.
  always @(posedge sys_clk) begin
    if (fifo_rd_en === 1'b1) begin
      pop_wait = 2;
      rd_pulses++;
    end else if (pop_wait > 0) begin
      pop_wait--;
      if (pop_wait == 0) begin
        #1;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_refresh();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge right after the start edge; leaves on the first idle cycle.
  task automatic run_frame(input logic [7:0] b, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int n = 0; n < 10 * CPB; n++) begin
      chk($sformatf("%s tx n=%0d", tag, n), 32'(tx), 32'(bits[n / CPB]));
      chk($sformatf("%s rd_en n=%0d", tag, n), 32'(fifo_rd_en), 32'(n == 0));
      chk($sformatf("%s done n=%0d", tag, n), 32'(frame_done), 32'(0));
      chk($sformatf("%s busy n=%0d", tag, n), 32'(busy), 32'(1));
      @(negedge sys_clk);
    end
    chk({tag, " done pulse"}, 32'(frame_done), 32'(1));
    chk({tag, " idle busy"}, 32'(busy), 32'(0));
    chk({tag, " idle tx"}, 32'(tx), 32'(1));
  endtask

  initial begin
    logic [10:0] bits_p1, bits_p2;
    fifo_refresh();
    repeat (3) @(negedge sys_clk);
    chk("reset tx", 32'(tx), 32'(1));
    chk("reset rd_en", 32'(fifo_rd_en), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(frame_done), 32'(0));
    chk("reset state", 32'(state), 32'(ST_IDLE));
    chk("reset p1 tx", 32'(p1_tx), 32'(1));
    chk("reset p2 tx", 32'(p2_tx), 32'(1));

    // Data and enable present while still in reset: nothing may start.
    fifo_q.push_back(8'hA5);
    fifo_refresh();
    tx_enable = 1'b1;
    @(negedge sys_clk);
    chk("held in reset tx", 32'(tx), 32'(1));
    chk("held in reset rd_en", 32'(fifo_rd_en), 32'(0));
    rst = 1'b0;
    @(negedge sys_clk);
    run_frame(8'hA5, "a5");

    for (int i = 0; i < 100; i++) begin
      chk($sformatf("empty rd_en c=%0d", i), 32'(fifo_rd_en), 32'(0));
      chk($sformatf("empty tx c=%0d", i), 32'(tx), 32'(1));
      @(negedge sys_clk);
    end
    chk("a5 fifo drained", 32'(fifo_q.size()), 32'(0));

    // Three back-to-back frames, one idle cycle apart.
    base = rd_pulses;
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    fifo_refresh();
    @(negedge sys_clk);
    run_frame(8'h01, "b2b 01");
    @(negedge sys_clk);
    run_frame(8'hFF, "b2b ff");
    @(negedge sys_clk);
    run_frame(8'h3C, "b2b 3c");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b2b after tx c=%0d", i), 32'(tx), 32'(1));
      chk($sformatf("b2b after busy c=%0d", i), 32'(busy), 32'(0));
      @(negedge sys_clk);
    end
    chk("b2b rd_en pulses", 32'(rd_pulses - base), 32'(3));
    chk("b2b fifo drained", 32'(fifo_q.size()), 32'(0));

    // Reset during data bit 3 of 0x5A (line bit 1); 0xC3 must follow.
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'hC3);
    fifo_refresh();
    @(negedge sys_clk);
    chk("abort start tx", 32'(tx), 32'(0));
    repeat (17) @(negedge sys_clk);
    chk("abort data3 tx", 32'(tx), 32'(1));
    chk("abort data3 state", 32'(state), 32'(ST_DATA));
    rst = 1'b1;
    @(negedge sys_clk);
    chk("abort tx", 32'(tx), 32'(1));
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(frame_done), 32'(0));
    chk("abort rd_en", 32'(fifo_rd_en), 32'(0));
    rst = 1'b0;
    @(negedge sys_clk);
    run_frame(8'hC3, "after abort c3");

    // Enable dropped during START: frame finishes, no further pop.
    fifo_q.push_back(8'h96);
    fifo_q.push_back(8'h11);
    fifo_refresh();
    @(negedge sys_clk);
    tx_enable = 1'b0;
    base = rd_pulses;
    run_frame(8'h96, "disable 96");
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("disabled tx c=%0d", i), 32'(tx), 32'(1));
      chk($sformatf("disabled rd_en c=%0d", i), 32'(fifo_rd_en), 32'(0));
      chk($sformatf("disabled busy c=%0d", i), 32'(busy), 32'(0));
      @(negedge sys_clk);
    end
    chk("disabled rd_en pulses", 32'(rd_pulses - base), 32'(1));
    chk("disabled fifo level", 32'(fifo_q.size()), 32'(1));
    tx_enable = 1'b1;
    @(negedge sys_clk);
    run_frame(8'h11, "reenable 11");
    tx_enable = 1'b0;

    // Parity frames for 0x07: even parity 1, odd parity 0, 11 bits long.
    bits_p1 = {1'b1, 1'b1, 8'h07, 1'b0};
    bits_p2 = {1'b1, 1'b0, 8'h07, 1'b0};
    p_enable = 1'b1;
    p_empty  = 1'b0;
    @(negedge sys_clk);
    p_enable = 1'b0;
    p_empty  = 1'b1;
    for (int n = 0; n < 11 * CPB; n++) begin
      chk($sformatf("even tx n=%0d", n), 32'(p1_tx), 32'(bits_p1[n / CPB]));
      chk($sformatf("odd tx n=%0d", n), 32'(p2_tx), 32'(bits_p2[n / CPB]));
      chk($sformatf("even rd_en n=%0d", n), 32'(p1_rd_en), 32'(n == 0));
      chk($sformatf("odd done n=%0d", n), 32'(p2_done), 32'(0));
      if (n / CPB == 9) chk($sformatf("even state n=%0d", n), 32'(p1_state), 32'(ST_PARITY));
      @(negedge sys_clk);
    end
    chk("even done pulse", 32'(p1_done), 32'(1));
    chk("odd done pulse", 32'(p2_done), 32'(1));
    chk("even idle busy", 32'(p1_busy), 32'(0));
    chk("odd idle busy", 32'(p2_busy), 32'(0));
    chk("odd rd_en idle", 32'(p2_rd_en), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port tx_enable, input, 1 bit: permits new frames to start.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: the byte FIFO's empty flag.
REQ-007 The block SHALL have port fifo_data, input, 8 bits: the FIFO head byte, valid whenever fifo_empty=0.
REQ-008 The block SHALL have port fifo_rd_en, output, 1 bit: pop request; the FIFO pops on its rising edge and commits 2 cycles later.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-012 The block SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is visited only when PARITY!=0.
REQ-013 In IDLE, on an edge where tx_enable=1 and fifo_empty=0, the block SHALL capture fifo_data into the shift register, set fifo_rd_en=1, set tx=0 and enter START, all at that same edge.
REQ-014 fifo_rd_en SHALL be registered and high for exactly one cycle per frame, then low for the rest of the frame.
REQ-015 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads at each bit boundary.
REQ-016 DATA SHALL shift out 8 bits LSB first, with a bit index running 0..7, then go to PARITY or STOP.
REQ-017 The parity bit SHALL be the XOR of the 8 data bits for even parity and its inverse for odd parity.
REQ-018 STOP SHALL drive tx=1; at the final STOP cycle the block SHALL pulse frame_done and return to IDLE.
REQ-019 IDLE SHALL be re-evaluated on the first IDLE cycle, so back-to-back frames are separated by exactly 1 idle cycle with tx=1.
REQ-020 The FIFO pop commits well before the next IDLE check, because a frame is at least 20 cycles; no extra settling wait SHALL be inserted.
REQ-021 If tx_enable falls mid-frame, the block SHALL finish the current frame and then stay in IDLE.
REQ-022 If fifo_empty=1 in IDLE, the block SHALL not pulse fifo_rd_en and tx SHALL stay 1.
REQ-023 tx, fifo_rd_en and frame_done SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL set state=IDLE, tx=1, fifo_rd_en=0, busy=0 and frame_done=0, and clear the counters and shift register.
REQ-025 A reset during a frame SHALL abort the frame immediately; the already-popped byte is lost and no frame_done pulse is issued.
REQ-026 The first frame after reset release SHALL start no earlier than the first edge with rst=0.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enumeration, the PARITY encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the frame constant DATA_BITS=8.
REQ-028 One sub-module, baud_gen, SHALL be used: a CLKS_PER_BIT down-counter with synchronous restart, producing a one-cycle bit_tick.
REQ-029 The block SHALL connect directly to the FIFO's rd_en, data_out and empty ports with no glue logic.

Verification
REQ-030 The bench SHALL cover: CLKS_PER_BIT=4, PARITY=0, FIFO holding 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; one fifo_rd_en pulse; frame_done at cycle 40.
REQ-031 The bench SHALL cover: FIFO holding 0x01, 0xFF, 0x3C with tx_enable held high -> three frames, each separated by 1 idle cycle; three rd_en pulses; FIFO empty afterwards; tx stays 1.
REQ-032 The bench SHALL cover: PARITY=1 with byte 0x07 -> parity bit 1; PARITY=2 with the same byte -> parity bit 0; frame length 11 bits.
REQ-033 The bench SHALL cover: rst asserted during DATA bit 3 -> next edge gives tx=1, busy=0 and no frame_done; the following frame starts with the next FIFO byte.
REQ-034 The bench SHALL cover: tx_enable dropped during START -> the frame completes normally with no new pop while tx_enable=0, even though fifo_empty=0.
REQ-035 The bench SHALL cover: an empty FIFO for 100 cycles with tx_enable=1 -> fifo_rd_en stays 0 and tx stays 1 throughout.
